// File: rtl/dadda_mul_arbiter.sv
// dadda_mul_arbiter
// Round-robin front end that time-shares one combinational multiplier among
// NREQ requesters. A granted operand pair is registered onto the multiplier
// inputs, given one cycle to settle, and the product is returned together
// with the owning requester's index over a valid/ready response port.
module dadda_mul_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  input  logic [2*WIDTH-1:0]      mul_product,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [1:0]              rsp_id,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic                    busy
);

  // Index width for selecting one of the requesters.
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // After reset the pointer sits on the last requester so requester 0 wins first.
  localparam logic [1:0] LAST_RST = 2'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         last_grant;
  logic               found;
  logic [1:0]         pick;
  logic               accept;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  // Round-robin search: first valid requester starting just after last_grant.
  always_comb begin
    int slot;
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    found = 1'b0;
    pick  = '0;
    slot  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      slot = (int'(last_grant) + k) % NREQ;
      if (!found && req_valid[IW'(slot)]) begin
        found = 1'b1;
        pick  = 2'(slot);
      end
    end
  end

  // A transfer happens whenever the arbiter offers a grant; the winner is by
  // construction valid, so the grant itself is the handshake.
  assign accept = (state == IDLE) && found;

  // One-hot grant decode and winner operand selection.
  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == 2'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
        if (accept && !reset) begin
          req_ready[i] = 1'b1;
        end
      end
    end
  end

  // Next-state logic: IDLE -> CALC on accept, one settle cycle, RESP until taken.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = CALC;
      CALC:                   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand, ownership and result registers; all change only at their own event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_id      <= '0;
      last_grant  <= LAST_RST;
      rsp_product <= '0;
    end else begin
      if (accept) begin
        mul_a      <= sel_a;
        mul_b      <= sel_b;
        rsp_id     <= pick;
        last_grant <= pick;
      end
      if (state == CALC) begin
        rsp_product <= mul_product;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// tb_dadda_mul_arbiter
// Self-checking bench: directed single-request vector table, contention,
// round-robin wrap, backpressure, mid-operation reset and idle hold. A
// negedge monitor keeps a scoreboard of accepted requests and checks every
// response against it.
module tb_dadda_mul_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic                  clock;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic [2*WIDTH-1:0]    mul_product;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [2*WIDTH-1:0]    rsp_product;
  logic                  busy;

  dadda_mul_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  // Stand-in for the shared combinational multiplier.
  assign mul_product = 8'(mul_a) * 8'(mul_b);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         id;
    logic [7:0] prod;
  } exp_t;

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;
  } vec_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   rsp_log[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: push on accept, pop and compare on response handshake.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (req_ready != '0) begin
        check("ready_onehot", 32'($onehot(req_ready)), 1);
        check("ready_without_valid", 32'(req_ready & ~req_valid), 0);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back('{id: i, prod: 8'(req_a[i*WIDTH +: WIDTH]) * 8'(req_b[i*WIDTH +: WIDTH])});
          grant_log.push_back(i);
        end
      end
      if (rsp_valid && rsp_ready) begin
        check("rsp_has_pending_request", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_rsp_id", 32'(rsp_id), e.id);
          check("sb_rsp_product", 32'(rsp_product), 32'(e.prod));
        end
        rsp_log.push_back(int'(rsp_product));
      end
    end
  end

  task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
  endtask

  task automatic apply_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    grant_log.delete();
    rsp_log.delete();
  endtask

  task automatic wait_ready(input string name, input int id);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clock);
      if (req_ready[id]) got = 1'b1;
    end
    check(name, 32'(got), 1);
  endtask

  task automatic wait_grants(input string name, input int n);
    for (int c = 0; c < 80 && grant_log.size() < n; c++) @(posedge clock);
    check(name, grant_log.size(), n);
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clock);
    check(name, exp_q.size(), 0);
  endtask

  // One complete transaction with the latency and handshake checked cycle by cycle.
  task automatic run_single(input int id, input logic [3:0] a, input logic [3:0] b,
                            input logic [7:0] prod);
    set_req(id, a, b);
    req_valid[id] = 1'b1;
    rsp_ready     = 1'b1;
    wait_ready("single_accept_wait", id);
    check("single_req_ready", 32'(req_ready), 32'(1) << id);
    @(posedge clock); #1;
    req_valid[id] = 1'b0;
    check("calc_busy", 32'(busy), 1);
    check("calc_rsp_valid", 32'(rsp_valid), 0);
    check("calc_mul_a", 32'(mul_a), 32'(a));
    check("calc_mul_b", 32'(mul_b), 32'(b));
    @(posedge clock); #1;
    check("resp_rsp_valid", 32'(rsp_valid), 1);
    check("resp_product", 32'(rsp_product), 32'(prod));
    check("resp_id", 32'(rsp_id), id);
    @(posedge clock); #1;
    check("done_rsp_valid", 32'(rsp_valid), 0);
    check("done_busy", 32'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_mul_a"}, 32'(mul_a), 0);
    check({tag, "_mul_b"}, 32'(mul_b), 0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 0);
    check({tag, "_rsp_product"}, 32'(rsp_product), 0);
  endtask

  initial begin
    int exp_g[5];
    int exp_p[5];

    vecs[0] = '{id: 0, a: 4'd5,  b: 4'd12, prod: 8'd60};
    vecs[1] = '{id: 1, a: 4'd15, b: 4'd15, prod: 8'd225};
    vecs[2] = '{id: 2, a: 4'd0,  b: 4'd9,  prod: 8'd0};
    vecs[3] = '{id: 3, a: 4'd7,  b: 4'd6,  prod: 8'd42};
    vecs[4] = '{id: 0, a: 4'd1,  b: 4'd1,  prod: 8'd1};
    vecs[5] = '{id: 2, a: 4'd15, b: 4'd1,  prod: 8'd15};
    vecs[6] = '{id: 1, a: 4'd8,  b: 4'd8,  prod: 8'd64};
    vecs[7] = '{id: 3, a: 4'd13, b: 4'd11, prod: 8'd143};

    reset     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset values, with requests pending to show req_ready stays low.
    #2;
    reset     = 1'b1;
    req_valid = 4'hF;
    #1;
    check_reset_outputs("reset");
    req_valid = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Single-request vector table.
    for (int v = 0; v < 8; v++) begin
      run_single(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].prod);
    end

    // Full contention straight after reset: grants 0,1,2,3,0.
    apply_reset();
    set_req(0, 4'd2, 4'd3);
    set_req(1, 4'd5, 4'd12);
    set_req(2, 4'd15, 4'd15);
    set_req(3, 4'd0, 4'd9);
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    wait_grants("contention_grants", 5);
    #1;
    req_valid = '0;
    drain("contention_drain");
    exp_g = '{0, 1, 2, 3, 0};
    exp_p = '{6, 60, 225, 0, 6};
    check("contention_rsp_count", rsp_log.size(), 5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) check("contention_grant_order", grant_log[k], exp_g[k]);
    for (int k = 0; k < 5 && k < rsp_log.size(); k++) check("contention_products", rsp_log[k], exp_p[k]);

    // Wrap with requesters 1 and 3 from last_grant = 3: grants 1,3,1.
    apply_reset();
    set_req(1, 4'd3, 4'd4);
    set_req(3, 4'd9, 4'd9);
    req_valid = 4'b1010;
    wait_grants("wrap_grants", 3);
    #1;
    req_valid = '0;
    drain("wrap_drain");
    exp_g = '{1, 3, 1, 0, 0};
    exp_p = '{12, 81, 12, 0, 0};
    for (int k = 0; k < 3 && k < grant_log.size(); k++) check("wrap_grant_order", grant_log[k], exp_g[k]);
    for (int k = 0; k < 3 && k < rsp_log.size(); k++) check("wrap_products", rsp_log[k], exp_p[k]);

    // Late requester 0 is served before 1 once the pointer sits at 3.
    grant_log.delete();
    rsp_log.delete();
    req_valid = 4'b1010;
    wait_grants("late_first_grant", 1);
    #1;
    set_req(0, 4'd6, 4'd7);
    req_valid[0] = 1'b1;
    wait_grants("late_grants", 3);
    #1;
    req_valid = '0;
    drain("late_drain");
    exp_g = '{3, 0, 1, 0, 0};
    exp_p = '{81, 42, 12, 0, 0};
    for (int k = 0; k < 3 && k < grant_log.size(); k++) check("late_grant_order", grant_log[k], exp_g[k]);
    for (int k = 0; k < 3 && k < rsp_log.size(); k++) check("late_products", rsp_log[k], exp_p[k]);

    // Backpressure: 15*15 held for 5 cycles while requester 1 waits.
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    set_req(2, 4'd15, 4'd15);
    req_valid = 4'b0100;
    wait_ready("bp_accept_wait", 2);
    @(posedge clock); #1;
    set_req(1, 4'd2, 4'd2);
    req_valid = 4'b0010;
    @(posedge clock); #1;
    repeat (5) begin
      @(negedge clock);
      check("bp_rsp_valid", 32'(rsp_valid), 1);
      check("bp_rsp_product", 32'(rsp_product), 225);
      check("bp_rsp_id", 32'(rsp_id), 2);
      check("bp_req_ready", 32'(req_ready), 0);
      check("bp_busy", 32'(busy), 1);
    end
    @(posedge clock); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    drain("bp_drain");
    #1;
    check("bp_done_busy", 32'(busy), 0);

    // Reset during CALC discards the in-flight 5*12.
    set_req(1, 4'd5, 4'd12);
    req_valid = 4'b0010;
    wait_ready("rst_calc_accept_wait", 1);
    @(posedge clock); #1;
    req_valid = '0;
    check("rst_calc_in_calc", 32'(busy), 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_calc");
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      check("rst_calc_no_rsp", 32'(rsp_valid), 0);
    end
    check("rst_calc_queue_flushed", exp_q.size(), 0);
    run_single(2, 4'd3, 4'd5, 8'd15);

    // Idle hold: nothing pending for 10 cycles.
    repeat (10) begin
      @(negedge clock);
      check("idle_busy", 32'(busy), 0);
      check("idle_req_ready", 32'(req_ready), 0);
      check("idle_rsp_valid", 32'(rsp_valid), 0);
      check("idle_mul_a", 32'(mul_a), 3);
      check("idle_mul_b", 32'(mul_b), 5);
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
